// File: rtl/serial_compare_if.sv
// rtl/serial_compare_if.sv - request/response bundle for the serial magnitude comparator
interface serial_compare_if #(
  parameter int N = 32
);
  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         signed_mode;
  logic         o_valid;
  logic         o_ready;
  logic         lt;
  logic         eq;
  logic         gt;

  modport master (
    output i_valid, a, b, signed_mode, o_ready,
    input  i_ready, o_valid, lt, eq, gt
  );

  modport slave (
    input  i_valid, a, b, signed_mode, o_ready,
    output i_ready, o_valid, lt, eq, gt
  );
endinterface

// File: rtl/serial_compare.sv
// rtl/serial_compare.sv - multi-cycle signed/unsigned comparator, W bits of a-b per cycle
module serial_compare #(
  parameter int N = 32,
  parameter int W = 8
) (
  input logic           clk,
  input logic           rst,
  serial_compare_if.slave bus
);
  localparam int CHUNKS = N / W;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  generate
    if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_param_err
      $error("serial_compare: N must be a positive multiple of W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic          r_signed;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic          r_zero;
  logic          r_lt;
  logic          r_eq;
  logic          r_gt;
  logic          r_i_ready;
  logic          r_o_valid;

  // Operands shift right each RUN cycle so the active chunk always sits in the low W bits.
  logic [W-1:0]  w_a_k;
  logic [W-1:0]  w_b_k;
  logic [W:0]    w_sum;
  logic [W-1:0]  w_s;
  logic          w_cout;
  logic          w_zero;
  logic          w_last;
  logic          w_lt_u;
  logic          w_lt_s;
  logic          w_lt;

  assign w_a_k  = r_a[W-1:0];
  assign w_b_k  = r_b[W-1:0];
  assign w_sum  = {1'b0, w_a_k} + {1'b0, ~w_b_k} + {{W{1'b0}}, r_carry};
  assign w_s    = w_sum[W-1:0];
  assign w_cout = w_sum[W];
  assign w_zero = r_zero & (w_s == '0);
  assign w_last = (r_cnt == LAST);
  assign w_lt_u = ~w_cout;
  // Differing signs decide directly, so the difference can never overflow into a wrong answer.
  assign w_lt_s = (w_a_k[W-1] != w_b_k[W-1]) ? w_a_k[W-1] : w_s[W-1];
  assign w_lt   = r_signed ? w_lt_s : w_lt_u;

  assign bus.i_ready = r_i_ready;
  assign bus.o_valid = r_o_valid;
  assign bus.lt      = r_lt;
  assign bus.eq      = r_eq;
  assign bus.gt      = r_gt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_signed  <= 1'b0;
      r_cnt     <= '0;
      r_carry   <= 1'b1;
      r_zero    <= 1'b1;
      r_lt      <= 1'b0;
      r_eq      <= 1'b0;
      r_gt      <= 1'b0;
      r_i_ready <= 1'b1;
      r_o_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_valid) begin
            r_a       <= bus.a;
            r_b       <= bus.b;
            r_signed  <= bus.signed_mode;
            r_cnt     <= '0;
            r_carry   <= 1'b1;
            r_zero    <= 1'b1;
            r_lt      <= 1'b0;
            r_eq      <= 1'b0;
            r_gt      <= 1'b0;
            r_i_ready <= 1'b0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> W;
          r_b     <= r_b >> W;
          r_carry <= w_cout;
          r_zero  <= w_zero;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_lt      <= w_lt;
            r_eq      <= w_zero;
            r_gt      <= ~w_lt & ~w_zero;
            r_o_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.o_ready) begin
            r_o_valid <= 1'b0;
            r_i_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_compare.sv
// tb/tb_serial_compare.sv - directed and randomized checks of serial_compare against a compare model
module tb_serial_compare;
  localparam int NTX = 1000;

  logic clk;
  logic rst;
  logic rst_sw;
  int   n_checks;
  int   n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [31:0] x, input logic [31:0] y, input bit sm);
    if (x == y) return 3'b010;
    if (sm) return ($signed(x) < $signed(y)) ? 3'b100 : 3'b001;
    return (x < y) ? 3'b100 : 3'b001;
  endfunction

  serial_compare_if #(.N(32)) dif ();
  serial_compare #(.N(32), .W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  // One instance per (W, mode) pair so the sweep runs concurrently.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_sweep
      localparam int SW = (gi / 2 == 0) ? 1 : ((gi / 2 == 1) ? 4 : 32);
      localparam bit SM = (gi % 2) == 1;
      serial_compare_if #(.N(32)) sif ();
      serial_compare #(.N(32), .W(SW)) u_dut (
        .clk (clk),
        .rst (rst_sw),
        .bus (sif.slave)
      );
      bit done;

      initial begin
        logic [31:0] va;
        logic [31:0] vb;
        logic [2:0]  exp_r;
        int          lat;
        done            = 1'b0;
        sif.i_valid     = 1'b0;
        sif.a           = '0;
        sif.b           = '0;
        sif.signed_mode = SM;
        sif.o_ready     = 1'b1;
        repeat (4) @(negedge clk);
        for (int t = 0; t < NTX; t++) begin
          va = $urandom;
          case ($urandom_range(0, 3))
            0:       vb = va;
            1:       vb = va ^ (32'h1 << $urandom_range(0, 31));
            default: vb = $urandom;
          endcase
          exp_r = ref_cmp(va, vb, SM);
          check($sformatf("sw%0d_m%0d_irdy", SW, SM), {63'd0, sif.i_ready}, 64'd1);
          sif.a       = va;
          sif.b       = vb;
          sif.i_valid = 1'b1;
          @(posedge clk);
          @(negedge clk);
          sif.i_valid = 1'b0;
          lat = 0;
          while (!sif.o_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
          end
          check($sformatf("sw%0d_m%0d_lat", SW, SM), 64'(lat), 64'(32 / SW));
          check($sformatf("sw%0d_m%0d_res a=%h b=%h", SW, SM, va, vb),
                {61'd0, sif.lt, sif.eq, sif.gt}, {61'd0, exp_r});
          @(negedge clk);
        end
        done = 1'b1;
      end
    end
  endgenerate

  initial begin
    rst_sw = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_sw = 1'b0;
  end

  task automatic do_txn(input logic [31:0] x, input logic [31:0] y, input bit sm,
                        output logic [2:0] res, output int lat);
    check("txn_irdy", {63'd0, dif.i_ready}, 64'd1);
    dif.a           = x;
    dif.b           = y;
    dif.signed_mode = sm;
    dif.i_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.i_valid = 1'b0;
    lat = 0;
    while (!dif.o_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = {dif.lt, dif.eq, dif.gt};
  endtask

  task automatic run_check(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input bit sm, input logic [2:0] exp_r);
    logic [2:0] res;
    int         lat;
    do_txn(x, y, sm, res, lat);
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_res"}, {61'd0, res}, {61'd0, exp_r});
    @(negedge clk);
    check({tag, "_ovalid_drop"}, {63'd0, dif.o_valid}, 64'd0);
  endtask

  initial begin
    logic [2:0]  res;
    int          lat;
    logic [31:0] va;
    logic [31:0] vb;
    int          cyc;
    bit          all_done;
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    dif.i_valid     = 1'b0;
    dif.a           = '0;
    dif.b           = '0;
    dif.signed_mode = 1'b0;
    dif.o_ready     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_irdy", {63'd0, dif.i_ready}, 64'd1);
    check("rst_ovalid", {63'd0, dif.o_valid}, 64'd0);
    check("rst_flags", {61'd0, dif.lt, dif.eq, dif.gt}, 64'd0);

    run_check("t1_s_m1_lt_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b100);
    run_check("t2_u_max_gt_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b001);
    run_check("t2_s_eq", 32'h8000_0000, 32'h8000_0000, 1'b1, 3'b010);
    run_check("t3_s_min_lt", 32'h8000_0000, 32'h0000_0001, 1'b1, 3'b100);
    run_check("t3_s_max_gt_min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 3'b001);
    run_check("t3_u_lt", 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 3'b100);

    // Backpressure with a pending request waiting behind it
    dif.o_ready = 1'b0;
    do_txn(32'h10, 32'h20, 1'b0, res, lat);
    check("t4_res", {61'd0, res}, 64'b100);
    va = $urandom;
    vb = $urandom;
    dif.a           = va;
    dif.b           = vb;
    dif.signed_mode = 1'b1;
    dif.i_valid     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t4_hold_ovalid", {63'd0, dif.o_valid}, 64'd1);
      check("t4_hold_irdy", {63'd0, dif.i_ready}, 64'd0);
      check("t4_hold_flags", {61'd0, dif.lt, dif.eq, dif.gt}, 64'b100);
    end
    dif.o_ready = 1'b1;
    @(negedge clk);
    check("t4_idle_ovalid", {63'd0, dif.o_valid}, 64'd0);
    check("t4_idle_irdy", {63'd0, dif.i_ready}, 64'd1);
    check("t4_idle_keep", {61'd0, dif.lt, dif.eq, dif.gt}, 64'b100);
    @(posedge clk);
    @(negedge clk);
    dif.i_valid = 1'b0;
    check("t4_run_irdy", {63'd0, dif.i_ready}, 64'd0);
    check("t4_run_flags", {61'd0, dif.lt, dif.eq, dif.gt}, 64'd0);
    lat = 0;
    while (!dif.o_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("t4_pend_lat", 64'(lat), 64'd4);
    check("t4_pend_res", {61'd0, dif.lt, dif.eq, dif.gt}, {61'd0, ref_cmp(va, vb, 1'b1)});
    @(negedge clk);

    // Reset two cycles into RUN
    dif.a       = 32'h1234_5678;
    dif.b       = 32'h0000_0001;
    dif.i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.i_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_irdy", {63'd0, dif.i_ready}, 64'd1);
    check("t5_ovalid", {63'd0, dif.o_valid}, 64'd0);
    check("t5_flags", {61'd0, dif.lt, dif.eq, dif.gt}, 64'd0);
    repeat (6) @(negedge clk);
    check("t5_stay_idle", {63'd0, dif.o_valid}, 64'd0);
    run_check("t5_eq", 32'd5, 32'd5, 1'b0, 3'b010);

    // Reset while a result is held in DONE
    dif.o_ready = 1'b0;
    do_txn(32'd1, 32'd2, 1'b0, res, lat);
    check("t5b_res", {61'd0, res}, 64'b100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dif.o_ready = 1'b1;
    check("t5b_ovalid", {63'd0, dif.o_valid}, 64'd0);
    check("t5b_irdy", {63'd0, dif.i_ready}, 64'd1);
    check("t5b_flags", {61'd0, dif.lt, dif.eq, dif.gt}, 64'd0);

    all_done = 1'b0;
    for (cyc = 0; cyc < 60000 && !all_done; cyc++) begin
      @(negedge clk);
      all_done = g_sweep[0].done && g_sweep[1].done && g_sweep[2].done &&
                 g_sweep[3].done && g_sweep[4].done && g_sweep[5].done;
    end
    check("sweep_done", {63'd0, all_done}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_compare.md
Name: serial_compare

Overview:
- Multi-cycle signed/unsigned magnitude comparator. Successor to the single-cycle combinational less-than block.
- Computes a - b one W-bit chunk per cycle, LSB chunk first, using a carry-chained adder (a + ~b + carry).
- Reports lt/eq/gt together, with a valid/ready handshake on both input and output.
- Used by the ALU and sort datapaths where N is too wide to close timing in one cycle.

Parameters:
- N, 32, operand width in bits; must be a multiple of W.
- W, 8, bits processed per cycle; 1 <= W <= N.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- i_valid  input  1  request valid.
- i_ready  output  1  block can accept a request.
- a  input  N  operand A.
- b  input  N  operand B.
- signed_mode  input  1  1 = operands are two's complement; 0 = unsigned.
- o_valid  output  1  result valid.
- o_ready  input  1  consumer accepts the result.
- lt  output  1  a < b.
- eq  output  1  a == b.
- gt  output  1  a > b.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, i_ready=1, o_valid=0, lt=eq=gt=0, chunk counter=0, carry=1, zero flag=1. Reset overrides everything, including mid-RUN and DONE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - i_ready=1, o_valid=0.
  - Accept occurs when i_valid=1 at an edge: latch a, b, signed_mode; clear lt/eq/gt to 0; carry=1; zero=1; counter=0; go to RUN.
  - After the accept, input port values are ignored until the next accept.
- RUN:
  - i_ready=0, o_valid=0.
  - Each cycle, chunk k = bits [k*W+W-1 : k*W] is summed: s = a_k + ~b_k + carry. Then carry <= carry-out, and zero <= zero AND (s == 0).
  - counter increments each cycle. On the final chunk (k = N/W - 1), capture sum MSB and the a/b MSBs, then go to DONE.
  - RUN lasts exactly N/W cycles. o_valid rises N/W cycles after the accept edge; W=N gives 1 cycle.
- Result, evaluated at the final-chunk edge:
  - eq = zero flag including the final chunk.
  - Unsigned mode: lt = NOT final carry-out.
  - Signed mode: if a_msb != b_msb, lt = a_msb; otherwise lt = sum_msb. This is overflow-safe.
  - gt = NOT lt AND NOT eq.
  - Exactly one of lt/eq/gt is 1 whenever o_valid=1.
- DONE:
  - o_valid=1, i_ready=0. lt/eq/gt are held stable.
  - If o_ready=1 at an edge, go to IDLE; o_valid drops and i_ready rises the next cycle.
  - Backpressure may last indefinitely; the result does not change and no request is accepted.
- Throughput: one result per N/W + 2 cycles at best (accept, N/W RUN, 1 DONE). The DONE→IDLE bubble is intentional; no overlap of consecutive requests.
- Output regs:
  - lt/eq/gt stay 0 from accept until entering DONE.
  - After handshake they retain the last result in IDLE. Consumers must qualify with o_valid.
- i_valid while i_ready=0 has no effect; the requester must hold the request until it sees i_ready.
- Parameter checks: elaboration fails if N % W != 0.

Test Plan:
1. N=32, W=8, signed_mode=1, a=32'hFFFF_FFFF, b=32'h0000_0001, o_ready=1 → o_valid high exactly 4 cycles after accept edge; lt=1, eq=0, gt=0; o_valid high for 1 cycle.
2. Same operands, signed_mode=0 → lt=0, eq=0, gt=1. Then a=b=32'h8000_0000, signed_mode=1 → eq=1, lt=0, gt=0.
3. Overflow cases:
   - signed a=32'h8000_0000, b=32'h0000_0001 → lt=1.
   - signed a=32'h7FFF_FFFF, b=32'h8000_0000 → gt=1.
   - unsigned a=32'h7FFF_FFFF, b=32'h8000_0000 → lt=1.
4. Backpressure: hold o_ready=0 for 6 cycles after o_valid rises; during that time drive new a/b and i_valid=1 → lt/eq/gt unchanged, i_ready=0, no new accept. Raise o_ready → IDLE next cycle; the pending request is accepted on the following edge and completes correctly.
5. Reset mid-operation: assert rst for 1 cycle 2 cycles into RUN → next cycle state IDLE, i_ready=1, o_valid=0, lt=eq=gt=0. A fresh request a=5, b=5 then yields eq=1 after 4 RUN cycles.
6. Parameter sweep W ∈ {1, 4, 32} with N=32: 1000 random operands per mode vs a reference model ($signed/unsigned compare) → all match, and latency = N/W cycles every time.
